pet_prg_loader: RTL

- Converts the HPS ioctl download stream into single-byte DMA writes into the PET memory map.
- Sits between hps_io (upstream) and the pet2001hw DMA port (downstream).
- PRG files (index PRG_INDEX): the 2-byte load address is stripped, the body is written to RAM, then the BASIC pointers (VARTAB/ARYTAB/STREND) are set to the end address.
- System ROM images (index ROM_INDEX) are written straight into the $8000-$FFFF window.

---
 rtl/pet_pkg.sv | 19 +
 rtl/pet_prg_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pet_pkg.sv
// Shared constants and state encoding for the PET download path.
package pet_pkg;

    localparam logic [7:0]  PRG_INDEX_DEF = 8'h41;
    localparam logic [7:0]  ROM_INDEX_DEF = 8'h02;
    localparam logic [15:0] PET_RAM_TOP   = 16'h8000;
    localparam logic [15:0] PET_VARTAB    = 16'h002A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_PTR_WR,
        S_PTR_GAP,
        S_ROM
    } loader_state_t;

endpackage

// File: rtl/pet_prg_loader.sv
// Turns the HPS ioctl download stream into single-byte PET DMA writes:
// PRG bodies into RAM followed by BASIC end pointers, ROM images into $8000-$FFFF.
module pet_prg_loader
    import pet_pkg::*;
#(
    parameter logic [7:0]  PRG_INDEX = PRG_INDEX_DEF,
    parameter logic [7:0]  ROM_INDEX = ROM_INDEX_DEF,
    parameter logic [15:0] RAM_TOP   = PET_RAM_TOP,
    parameter logic [15:0] PTR_BASE  = PET_VARTAB,
    parameter int          PTR_PAIRS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [2:0] PTR_LAST = 3'(2 * PTR_PAIRS - 1);

    loader_state_t state, state_n;
    logic [15:0]   load_addr, load_n, addr_n;
    logic [7:0]    din_n;
    logic [2:0]    cnt, cnt_n;
    logic          we_n, busy_n, done_n, ovf_n;
    logic          dl_q, dl_rise, dl_fall;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dma_addr  <= '0;
            dma_din   <= '0;
            dma_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            load_addr <= '0;
            cnt       <= '0;
            dl_q      <= 1'b0;
        end else begin
            state     <= state_n;
            dma_addr  <= addr_n;
            dma_din   <= din_n;
            dma_we    <= we_n;
            busy      <= busy_n;
            done      <= done_n;
            overflow  <= ovf_n;
            load_addr <= load_n;
            cnt       <= cnt_n;
            dl_q      <= ioctl_download;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = dma_addr;
        din_n   = dma_din;
        we_n    = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        ovf_n   = overflow;
        load_n  = load_addr;
        cnt_n   = cnt;

        // A new download also cuts short a pending pointer sequence, with no done pulse.
        if (dl_rise && (state == S_IDLE || state == S_PTR_WR || state == S_PTR_GAP)) begin
            if (ioctl_index == PRG_INDEX) begin
                state_n = S_HDR_LO;
                ovf_n   = 1'b0;
                busy_n  = 1'b1;
            end else if (ioctl_index == ROM_INDEX) begin
                state_n = S_ROM;
                busy_n  = 1'b1;
            end else begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        end else begin
            case (state)
                S_HDR_LO, S_HDR_HI: begin
                    if (dl_fall) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else if (ioctl_wr && ioctl_addr == 25'd0) begin
                        load_n[7:0] = ioctl_dout;
                        state_n     = S_HDR_HI;
                    end else if (ioctl_wr && ioctl_addr == 25'd1) begin
                        load_n[15:8] = ioctl_dout;
                        state_n      = S_DATA;
                    end
                end
                S_DATA: begin
                    if (dl_fall) begin
                        cnt_n   = '0;
                        state_n = S_PTR_WR;
                    end else if (ioctl_wr) begin
                        if (load_addr < RAM_TOP) begin
                            addr_n = load_addr;
                            din_n  = ioctl_dout;
                            we_n   = 1'b1;
                            load_n = load_addr + 16'd1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                end
                S_PTR_WR: begin
                    addr_n  = PTR_BASE + 16'(cnt);
                    din_n   = cnt[0] ? load_addr[15:8] : load_addr[7:0];
                    we_n    = 1'b1;
                    state_n = S_PTR_GAP;
                end
                S_PTR_GAP: begin
                    cnt_n = cnt + 3'd1;
                    if (cnt == PTR_LAST) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = S_PTR_WR;
                    end
                end
                S_ROM: begin
                    if (dl_fall) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else if (ioctl_wr && ioctl_addr < 25'h8000) begin
                        addr_n = {1'b1, ioctl_addr[14:0]};
                        din_n  = ioctl_dout;
                        we_n   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
